// File: rtl/cdec8_res_dump_tx_if.sv
// Resource-observation and UART port bundle for the CDEC8 debug dump reader.
// master is the dump reader; slave is the data path / top-level side.
interface cdec8_res_dump_tx_if;
  logic       trigger;
  logic [7:0] resad;
  logic [7:0] resdt;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (input trigger, input resdt, output resad, output tx, output busy, output done);
  modport slave  (output trigger, output resdt, input resad, input tx, input busy, input done);
endinterface

// File: rtl/cdec8_res_dump_tx.sv
// Scans resource addresses 0..RES_LAST on trigger and ships header, data bytes
// and an 8-bit additive checksum as one UART 8N1 frame.
module cdec8_res_dump_tx #(
  parameter int         CLK_DIV  = 434,
  parameter logic [7:0] RES_LAST = 8'h0F,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic clock,
  input  logic reset,
  cdec8_res_dump_tx_if.master bus
);

  localparam int             BW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0]  BAUD_TOP = BW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, HDR, SETUP, CAPT, DATA, CSUM, FIN} state_t;

  state_t        state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [3:0]    bit_cnt, bit_d;
  logic [9:0]    frame, frame_d;
  logic [7:0]    addr, addr_d;
  logic [7:0]    csum, csum_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    resad_q, resad_d;

  logic sending, bit_end, byte_end;

  // Bits are shifted out of frame[0]: start(0), b[0..7], stop(1).
  function automatic logic [9:0] uart_frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  assign sending  = (state == HDR) || (state == DATA) || (state == CSUM);
  assign bit_end  = (baud == '0);
  assign byte_end = bit_end && (bit_cnt == 4'd9);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state;
    baud_d  = baud;
    bit_d   = bit_cnt;
    frame_d = frame;
    addr_d  = addr;
    csum_d  = csum;
    tx_d    = 1'b1;
    busy_d  = busy_q;
    done_d  = 1'b0;
    resad_d = resad_q;

    // Shared bit timer; counter reloads at each boundary so bit periods never drift.
    if (sending) begin
      tx_d = frame[0];
      if (bit_end) begin
        baud_d = BAUD_TOP;
        if (!byte_end) begin
          bit_d   = bit_cnt + 4'd1;
          frame_d = {1'b1, frame[9:1]};
          tx_d    = frame_d[0];
        end
      end else begin
        baud_d = baud - BW'(1);
      end
    end

    case (state)
      IDLE, FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        // FIN also samples trigger so a held trigger restarts with no idle cycle.
        if (bus.trigger) begin
          state_d = HDR;
          frame_d = uart_frame(HDR_BYTE);
          baud_d  = BAUD_TOP;
          bit_d   = 4'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          csum_d  = 8'h00;
          addr_d  = 8'h00;
          resad_d = 8'h00;
        end
      end
      HDR: begin
        if (byte_end) begin
          state_d = SETUP;
          resad_d = addr;
          tx_d    = 1'b1;
        end
      end
      SETUP: state_d = CAPT;
      CAPT: begin
        state_d = DATA;
        frame_d = uart_frame(bus.resdt);
        csum_d  = csum + bus.resdt;
        baud_d  = BAUD_TOP;
        bit_d   = 4'd0;
        tx_d    = 1'b0;
      end
      DATA: begin
        if (byte_end) begin
          if (addr == RES_LAST) begin
            state_d = CSUM;
            frame_d = uart_frame(csum);
            baud_d  = BAUD_TOP;
            bit_d   = 4'd0;
            tx_d    = 1'b0;
          end else begin
            state_d = SETUP;
            addr_d  = addr + 8'd1;
            resad_d = addr + 8'd1;
            tx_d    = 1'b1;
          end
        end
      end
      CSUM: begin
        if (byte_end) begin
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          resad_d = 8'h00;
          tx_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= 4'd0;
      frame   <= '1;
      addr    <= 8'h00;
      csum    <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resad_q <= 8'h00;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_cnt <= bit_d;
      frame   <= frame_d;
      addr    <= addr_d;
      csum    <= csum_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      resad_q <= resad_d;
    end
  end

  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.resad = resad_q;

endmodule

// File: tb/tb_cdec8_res_dump_tx.sv
// Self-checking bench: a byte-level frame model expands into the expected
// per-cycle tx/resad/busy/done trace, and a UART receiver decodes tx.
module tb_cdec8_res_dump_tx;

  localparam int CD = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cdec8_res_dump_tx_if bus_a ();
  cdec8_res_dump_tx_if bus_b ();

  cdec8_res_dump_tx #(.CLK_DIV(CD), .RES_LAST(8'h0F), .HDR_BYTE(8'hA5)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a.master));
  cdec8_res_dump_tx #(.CLK_DIV(CD), .RES_LAST(8'h00), .HDR_BYTE(8'hA5)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b.master));

  logic [7:0] mem [0:255];
  logic       trig;
  logic       sel_b;

  always_comb bus_a.trigger = trig & ~sel_b;
  always_comb bus_b.trigger = trig & sel_b;
  always_comb bus_a.resdt   = mem[bus_a.resad];
  always_comb bus_b.resdt   = mem[bus_b.resad];

  logic       p_tx, p_busy, p_done;
  logic [7:0] p_resad;
  always_comb begin
    p_tx    = sel_b ? bus_b.tx    : bus_a.tx;
    p_busy  = sel_b ? bus_b.busy  : bus_a.busy;
    p_done  = sel_b ? bus_b.done  : bus_a.done;
    p_resad = sel_b ? bus_b.resad : bus_a.resad;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic       cap_tx    [0:1023];
  logic       cap_busy  [0:1023];
  logic       cap_done  [0:1023];
  logic [7:0] cap_resad [0:1023];

  typedef enum int {K_ADD, K_CONST} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] k;
    int         n;
    logic [7:0] exp_csum;
  } vec_t;

  task automatic fill_mem(input kind_t kind, input logic [7:0] k);
    for (int a = 0; a < 256; a++) mem[a] = (kind == K_ADD) ? 8'(a) + k : k;
  endtask

  // Runs one frame on DUT A (n=16) or DUT B (n=1) and checks it completely.
  task automatic run_frame(input int n, input logic [7:0] exp_csum, input bit started,
                           input int pulse_at, input bit hold, input string tag);
    int         len, last;
    logic [7:0] bytes[$];
    int         exp_tx[$];
    int         exp_ra[$];
    logic [7:0] dec[$];
    logic [9:0] hdr_pat;
    int         bad_tx, bad_busy, bad_ra, n_done, bad_hdr, bad_bytes, idx, first_bad;
    logic [7:0] b, last_b;

    sel_b = (n == 1);
    len   = (n + 2) * 10 * CD + 2 * n;
    last  = hold ? len : len + 1;

    bytes.push_back(8'hA5);
    for (int i = 0; i < n; i++) bytes.push_back(mem[i]);
    bytes.push_back(exp_csum);
    for (int bi = 0; bi < n + 2; bi++) begin
      b = bytes[bi];
      if (bi >= 1 && bi <= n) begin
        repeat (2) begin exp_tx.push_back(1); exp_ra.push_back(bi - 1); end
      end
      for (int j = 0; j < 10; j++)
        for (int r = 0; r < CD; r++) begin
          exp_tx.push_back((j == 0) ? 0 : (j == 9) ? 1 : int'(b[j-1]));
          exp_ra.push_back((bi >= 1 && bi <= n) ? bi - 1 : -1);
        end
    end

    if (!started) begin
      @(negedge clock);
      trig = 1'b1;
      @(posedge clock);
    end
    for (int c = 0; c <= last; c++) begin
      @(negedge clock);
      cap_tx[c]    = p_tx;
      cap_busy[c]  = p_busy;
      cap_done[c]  = p_done;
      cap_resad[c] = p_resad;
      trig = hold || (c == pulse_at);
    end

    bad_tx = 0; bad_busy = 0; bad_ra = 0; n_done = 0; first_bad = -1;
    for (int c = 0; c < len; c++) begin
      if (cap_tx[c] !== 1'(exp_tx[c])) begin
        bad_tx++;
        if (first_bad < 0) first_bad = c;
      end
      if (cap_busy[c] !== 1'b1) bad_busy++;
      if (exp_ra[c] >= 0 && cap_resad[c] !== 8'(exp_ra[c])) bad_ra++;
      if (cap_done[c] !== 1'b0) n_done++;
    end
    check($sformatf("%s tx trace bad cycles (first %0d)", tag, first_bad), bad_tx, 0);
    check({tag, " busy high in frame"}, bad_busy, 0);
    check({tag, " resad per data byte"}, bad_ra, 0);
    check({tag, " done early"}, n_done, 0);
    check({tag, " done at frame end"}, {cap_done[len], cap_busy[len], cap_tx[len]}, 3'b101);
    if (!hold)
      check({tag, " idle after FIN"}, {cap_done[len+1], cap_busy[len+1], cap_tx[len+1]}, 3'b001);

    hdr_pat = 10'b1101001010;
    bad_hdr = 0;
    for (int c = 0; c < 10 * CD; c++) if (cap_tx[c] !== hdr_pat[c / CD]) bad_hdr++;
    check({tag, " header bit levels"}, bad_hdr, 0);

    idx = 0;
    while (idx + 10 * CD <= len) begin
      if (cap_tx[idx] == 1'b0) begin
        for (int j = 0; j < 8; j++) b[j] = cap_tx[idx + (j + 1) * CD + CD / 2];
        dec.push_back(b);
        idx += 10 * CD;
      end else begin
        idx++;
      end
    end
    check({tag, " decoded byte count"}, dec.size(), n + 2);
    bad_bytes = 0;
    for (int i = 0; i < n + 2 && i < dec.size(); i++) if (dec[i] !== bytes[i]) bad_bytes++;
    check({tag, " decoded bytes"}, bad_bytes, 0);
    last_b = (dec.size() > 0) ? dec[dec.size() - 1] : 8'hxx;
    check({tag, " checksum byte"}, last_b, exp_csum);
  endtask

  vec_t vecs[6];
  int   sum;

  initial begin
    vecs[0] = '{K_ADD,   8'h10, 16, 8'h78};
    vecs[1] = '{K_CONST, 8'hFF, 16, 8'hF0};
    vecs[2] = '{K_CONST, 8'h5A, 1,  8'h5A};
    vecs[3] = '{K_CONST, 8'h00, 16, 8'h00};
    vecs[4] = '{K_ADD,   8'h00, 16, 8'h78};
    vecs[5] = '{K_ADD,   8'hF8, 16, 8'hF8};

    trig  = 1'b0;
    sel_b = 1'b0;
    fill_mem(K_CONST, 8'h00);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset A", {bus_a.tx, bus_a.busy, bus_a.done, bus_a.resad}, {3'b100, 8'h00});
    check("reset B", {bus_b.tx, bus_b.busy, bus_b.done, bus_b.resad}, {3'b100, 8'h00});
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      fill_mem(vecs[i].kind, vecs[i].k);
      run_frame(vecs[i].n, vecs[i].exp_csum, 1'b0, (i == 0) ? 300 : -1, 1'b0,
                $sformatf("vec%0d", i));
      repeat (3) @(negedge clock);
    end

    // Reset in the middle of data byte 3, then a clean frame.
    sel_b = 1'b0;
    fill_mem(K_ADD, 8'h10);
    @(negedge clock);
    trig = 1'b1;
    @(posedge clock);
    @(negedge clock);
    trig = 1'b0;
    repeat (185) @(negedge clock);
    check("mid-frame resad before reset", p_resad, 8'h03);
    #2 reset = 1'b1;
    #1 check("async reset outputs", {p_tx, p_busy, p_done, p_resad}, {3'b100, 8'h00});
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    run_frame(16, 8'h78, 1'b0, -1, 1'b0, "after reset");

    // Trigger held across FIN: back-to-back frames.
    run_frame(16, 8'h78, 1'b0, -1, 1'b1, "hold first");
    run_frame(16, 8'h78, 1'b1, -1, 1'b0, "hold second");

    for (int r = 0; r < 5; r++) begin
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      sum = 0;
      for (int a = 0; a < ((r == 4) ? 1 : 16); a++) sum += int'(mem[a]);
      run_frame((r == 4) ? 1 : 16, 8'(sum % 256), 1'b0, (r == 1) ? 500 : -1, 1'b0,
                $sformatf("rand%0d", r));
      repeat (2) @(negedge clock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
